instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Instruction-fetch front end for the single-cycle MIPS datapath. It holds the PC and a loadable word-addressed instruction memory, and presents Instruction to the controller each cycle. It consumes the controller's Branch/Jump outputs and the ALU Zero flag to compute the next PC, and counts retired instructions. A host load port fills the memory before or between runs.

Parameters:
DEPTH, 256, number of 32-bit instruction words; power of two.
AW, 8, load address width; equals log2(DEPTH).
RESET_PC, 32'h00000000, PC value on reset; word-aligned and below DEPTH*4.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
run  input  1  advance PC this cycle when high
Branch  input  1  from controller; beq instruction
Jump  input  1  from controller; j instruction
Zero  input  1  from ALU; operands equal
load_we  input  1  host write strobe into instruction memory
load_addr  input  AW  host word address
load_data  input  32  host write data
PC  output  32  current program counter
PC_plus4  output  32  PC+4, modulo 2^32
Instruction  output  32  word at imem[PC[AW+1:2]], to controller
instr_count  output  32  retired-instruction counter
fault  output  1  sticky fetch-out-of-range flag

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset, asserted asynchronously at any time including mid-run:
  - PC=RESET_PC, instr_count=0, fault=0.
  - Instruction is forced to 0 while rst is high.
  - Memory contents are retained, never cleared.
- Instruction read is combinational from PC, so it is valid in the same cycle as PC; single-cycle latency.
- Memory write is synchronous. At the edge with load_we=1, imem[load_addr]<=load_data. If load_addr matches the current PC word, Instruction shows the new data after that edge.
- Advance condition: adv = run & ~load_we & ~fault. load_we has priority over run; PC is held during any load cycle.
- Next-PC selection on adv:
  - Jump=1: {PC_plus4[31:28], Instruction[25:0], 2'b00}.
  - else Branch&Zero: PC_plus4 + ({{14{Instruction[15]}}, Instruction[15:0], 2'b00}).
  - else: PC_plus4.
  - Jump wins if Jump and Branch are both set. Branch with Zero=0 falls through to PC+4.
  - All arithmetic is 32-bit modulo 2^32; negative branch offsets wrap naturally.
- Range check: if adv and the selected next PC is >= DEPTH*4:
  - PC holds its value.
  - fault<=1, sticky until rst.
  - instr_count does not increment.
- While fault=1: Instruction is forced to 0 (nop), and the PC is frozen.
- instr_count increments by 1 on every adv edge that does not fault. It saturates at 32'hFFFFFFFF.
- run=0: PC and instr_count hold; Instruction keeps reflecting imem[PC].
- Branch/Jump/Zero are ignored when adv=0.

Decomposition:
- Shared header (opcode/funct constants already used by the controller): OP_RTYPE=6'h00, OP_J=6'h02, OP_BEQ=6'h04, OP_ADDIU=6'h09, OP_ORI=6'h0D, OP_LW=6'h23, OP_SW=6'h2B. Place WORD_BYTES=4 there too.
- One sub-module, imem_sp:
  - DEPTH x 32 array.
  - Synchronous write port.
  - Combinational read port.
- Next-PC mux, range check, counter and fault logic stay in instr_fetch_unit.

Test Plan:
1. Load and run sequence:
   - Stimulus: load words 0..10 with 00222820, 00222822, 00222823, 0022282A, 0022282B, 34220001, 24220001, 8c220001, ac220001, 10220002, 08000001; rst pulse; run=1, Branch=Jump=0.
   - Required: PC=0x00,0x04,…,0x28 on successive cycles; Instruction matches each word; instr_count=10 at PC=0x28.
2. Branch taken:
   - Stimulus: PC=0x24 (10220002), Branch=1, Zero=1.
   - Required: next PC=0x30. Repeat with Zero=0 → next PC=0x28.
3. Jump:
   - Stimulus: PC=0x28 (08000001), Jump=1 and Branch=1 together.
   - Required: next PC=0x00000004 (Jump has priority).
4. Load priority and hazard:
   - Stimulus: run=1 with load_we=1, load_addr=PC word, load_data=32'h0022282A.
   - Required: PC unchanged, instr_count unchanged; after the edge, Instruction=0022282A.
5. Fault:
   - Stimulus: DEPTH=256, word at 0x3FC = 32'h00000000, run from PC=0x3FC.
   - Required: next PC 0x400 is out of range → PC stays 0x3FC, fault=1, Instruction=0, instr_count unchanged; fault persists with run=1 until rst.
6. Asynchronous reset mid-run:
   - Stimulus: assert rst between edges while PC=0x14.
   - Required: PC=0, instr_count=0, fault=0 immediately with no clock edge; memory word 5 still reads 34220001 after release.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared MIPS front-end constants and next-PC helpers.
// Opcode values match the controller's decoder.
package instr_fetch_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int WORD_BYTES = 4;

  function automatic logic [31:0] br_off(
    input logic [15:0] imm
  );
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

  function automatic logic [31:0] j_tgt(
    input logic [3:0]  hi,
    input logic [25:0] idx
  );
    return {hi, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_sp.sv
// Instruction memory: synchronous write port,
// combinational read port, contents never reset.
module imem_sp #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC, next-PC select, range
// fault, retired-instruction counter.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 256,
  parameter int          AW       = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          Branch,
  input  logic          Jump,
  input  logic          Zero,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  output logic [31:0]   PC,
  output logic [31:0]   PC_plus4,
  output logic [31:0]   Instruction,
  output logic [31:0]   instr_count,
  output logic          fault
);

  localparam logic [31:0] LIMIT =
    32'(DEPTH * WORD_BYTES);

  logic [31:0] rdata;
  logic [31:0] next_pc;
  logic        adv;
  logic        in_range;

  imem_sp #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_imem (
    .clk  (clk),
    .we   (load_we),
    .waddr(load_addr),
    .wdata(load_data),
    .raddr(PC[AW+1:2]),
    .rdata(rdata)
  );

  assign PC_plus4    = PC + 32'd4;
  assign Instruction = (rst || fault) ? '0 : rdata;
  assign adv         = run & ~load_we & ~fault;

  // Jump outranks a simultaneous taken branch
  always_comb begin
    next_pc = PC_plus4;
    priority case (1'b1)
      Jump:
        next_pc = j_tgt(PC_plus4[31:28],
                        Instruction[25:0]);
      Branch & Zero:
        next_pc = PC_plus4 +
                  br_off(Instruction[15:0]);
      default:
        next_pc = PC_plus4;
    endcase
  end

  assign in_range = next_pc < LIMIT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC          <= RESET_PC;
      instr_count <= '0;
      fault       <= 1'b0;
    end else if (adv) begin
      if (in_range) begin
        PC <= next_pc;
        if (instr_count != '1)
          instr_count <= instr_count + 32'd1;
      end else begin
        fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a
// word-level reference model and random phase.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        Branch = 1'b0;
  logic        Jump = 1'b0;
  logic        Zero = 1'b0;
  logic        load_we = 1'b0;
  logic [7:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic [31:0] PC, PC_plus4, Instruction;
  logic [31:0] instr_count;
  logic        fault;

  instr_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .Branch     (Branch),
    .Jump       (Jump),
    .Zero       (Zero),
    .load_we    (load_we),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .PC         (PC),
    .PC_plus4   (PC_plus4),
    .Instruction(Instruction),
    .instr_count(instr_count),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] p4;
    logic [31:0] ins;
    logic [31:0] cnt;
    logic        flt;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // reference model state
  logic [31:0] m_mem [256];
  logic [31:0] m_pc  = 0;
  logic [31:0] m_cnt = 0;
  bit          m_flt = 0;

  logic [31:0] prog [11] = '{
    32'h00222820, 32'h00222822, 32'h00222823,
    32'h0022282A, 32'h0022282B, 32'h34220001,
    32'h24220001, 32'h8c220001, 32'hac220001,
    32'h10220002, 32'h08000001
  };

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h",
                  name, act, req);
  endtask

  function automatic logic [31:0] m_ins();
    return m_flt ? 32'h0 : m_mem[m_pc[9:2]];
  endfunction

  task automatic m_reset();
    m_pc  = 0;
    m_cnt = 0;
    m_flt = 0;
  endtask

  task automatic m_step(input bit r, b, j, z, w,
                        input logic [7:0]  la,
                        input logic [31:0] ld);
    logic [31:0] ins, p4, np;
    int          off;
    ins = m_ins();
    if (w) m_mem[la] = ld;
    if (r && !w && !m_flt) begin
      p4  = m_pc + 4;
      off = $signed(ins[15:0]);
      if (j)
        np = {p4[31:28], ins[25:0], 2'b00};
      else if (b && z)
        np = p4 + 32'(off * 4);
      else
        np = p4;
      if (np >= 32'd1024) begin
        m_flt = 1;
      end else begin
        m_pc = np;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
      end
    end
  endtask

  // one clock of stimulus; optional async reset
  // pulse in the low phase before driving
  task automatic cyc(input bit r, b, j, z, w,
                     input logic [7:0]  la,
                     input logic [31:0] ld,
                     input bit do_rst);
    exp_t e;
    @(negedge clk);
    if (do_rst) begin
      rst = 1'b1;
      m_reset();
      #1;
      chk("rst_pc", PC, 32'h0);
      chk("rst_cnt", instr_count, 32'h0);
      chk("rst_fault", 32'(fault), 32'h0);
      chk("rst_ins", Instruction, 32'h0);
      rst = 1'b0;
    end
    run = r; Branch = b; Jump = j; Zero = z;
    load_we = w; load_addr = la; load_data = ld;
    m_step(r, b, j, z, w, la, ld);
    e.pc  = m_pc;
    e.p4  = m_pc + 4;
    e.ins = m_ins();
    e.cnt = m_cnt;
    e.flt = m_flt;
    exp_q.push_back(e);
  endtask

  task automatic go(input int n);
    for (int i = 0; i < n; i++)
      cyc(1, 0, 0, 0, 0, 8'd0, 32'd0, 0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc", PC, e.pc);
      chk("pc_plus4", PC_plus4, e.p4);
      chk("instruction", Instruction, e.ins);
      chk("instr_count", instr_count, e.cnt);
      chk("fault", 32'(fault), 32'(e.flt));
    end
  end

  initial begin
    logic [31:0] w;
    bit          rr;
    #1;
    chk("init_pc", PC, 32'h0);
    chk("init_cnt", instr_count, 32'h0);
    chk("init_fault", 32'(fault), 32'h0);
    chk("init_ins", Instruction, 32'h0);
    #2 rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      w = (i < 11) ? prog[i] :
          (i == 20) ? 32'h080000FF : 32'h0;
      cyc(0, 0, 0, 0, 1, 8'(i), w, 0);
    end
    // sequential run to 0x28
    cyc(1, 0, 0, 0, 0, 8'd0, 32'd0, 1);
    go(9);
    // branch taken and not taken at 0x24
    cyc(0, 0, 0, 0, 0, 8'd0, 32'd0, 1);
    go(9);
    cyc(1, 1, 0, 1, 0, 8'd0, 32'd0, 0);
    cyc(0, 0, 0, 0, 0, 8'd0, 32'd0, 1);
    go(9);
    cyc(1, 1, 0, 0, 0, 8'd0, 32'd0, 0);
    // jump beats branch at 0x28
    cyc(1, 1, 1, 1, 0, 8'd0, 32'd0, 0);
    // load over current PC word while running
    cyc(1, 0, 0, 0, 1, 8'd1, 32'h0022282A, 0);
    go(1);
    // reach 0x3FC via branch then jump, then fault
    cyc(0, 0, 0, 0, 0, 8'd0, 32'd0, 1);
    go(9);
    cyc(1, 1, 0, 1, 0, 8'd0, 32'd0, 0);
    go(8);
    cyc(1, 0, 1, 0, 0, 8'd0, 32'd0, 0);
    go(4);
    // async reset mid-run at 0x14
    cyc(0, 0, 0, 0, 0, 8'd0, 32'd0, 1);
    go(5);
    cyc(1, 0, 0, 0, 0, 8'd0, 32'd0, 1);
    go(4);
    // random phase on random in-range code
    for (int i = 0; i < 256; i++)
      cyc(0, 0, 0, 0, 1, 8'(i),
          $urandom & 32'hFC0000FF, 0);
    for (int i = 0; i < 600; i++) begin
      rr = ($urandom_range(0, 39) == 0);
      w  = $urandom;
      cyc(w[0] | w[1], w[2], w[3] & w[4], w[5],
          (w[10:8] == 3'd0), w[23:16],
          $urandom & 32'hFC0000FF, rr);
    end
    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
